// File: rtl/reboot_trigger.sv
`default_nettype none
// ============================================================================
// Module   : reboot_trigger
// Purpose  : Requests a board reset after either a MAGIC byte sequence arrives
//            on the UART receive stream or the user button is held low long
//            enough. A fixed countdown separates the trigger from do_reset so
//            the UART transmitter can drain; the countdown can be cancelled.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk       in   1  single clock, rising edge
//   rst       in   1  asynchronous active-high reset
//   rx_data   in   8  received byte
//   rx_valid  in   1  rx_data holds a valid byte
//   rx_ready  out  1  byte accepted when rx_valid & rx_ready at an edge
//   btn_n     in   1  active-low user button, asynchronous to clk
//   cancel    in   1  aborts a pending countdown
//   pending   out  1  countdown running or reset already issued
//   do_reset  out  1  sticky reset request to the board reset block
// ============================================================================
module reboot_trigger #(
  parameter logic [31:0] MAGIC        = 32'h52535421,
  parameter int unsigned HOLD_CYCLES  = 48000000,
  parameter int unsigned DELAY_CYCLES = 1200000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready,
  input  logic       btn_n,
  input  logic       cancel,
  output logic       pending,
  output logic       do_reset
);

  // One extra bit so the counters can hold the parameter value itself.
  localparam int unsigned HOLD_W  = $clog2(HOLD_CYCLES) + 1;
  localparam int unsigned DELAY_W = $clog2(DELAY_CYCLES) + 1;

  localparam logic [HOLD_W-1:0]  c_HOLD_MAX   = HOLD_W'(HOLD_CYCLES);
  localparam logic [HOLD_W-1:0]  c_HOLD_LAST  = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [HOLD_W-1:0]  c_HOLD_ONE   = HOLD_W'(1);
  localparam logic [DELAY_W-1:0] c_DELAY_LOAD = DELAY_W'(DELAY_CYCLES - 1);
  localparam logic [DELAY_W-1:0] c_DELAY_ONE  = DELAY_W'(1);
  localparam logic [DELAY_W-1:0] c_DELAY_ZERO = '0;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_COUNTDOWN = 2'd1,
    S_FIRED     = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          idx_q, idx_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [DELAY_W-1:0]  delay_q, delay_d;
  logic                sync1_q, sync2_q;
  logic                ready_en_q;

  logic                w_accept;
  logic                w_byte_trig;
  logic                w_btn_trig;

  // MAGIC is matched most significant byte first.
  function automatic logic [7:0] magic_byte(input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = MAGIC[31:24];
      2'd1:    b = MAGIC[23:16];
      2'd2:    b = MAGIC[15:8];
      default: b = MAGIC[7:0];
    endcase
    return b;
  endfunction

  // ready_en_q keeps rx_ready low while rst is held and lets it rise on the
  // first edge after release, independent of the FSM state.
  assign rx_ready = ready_en_q & (state_q == S_IDLE);
  assign pending  = (state_q != S_IDLE);
  assign do_reset = (state_q == S_FIRED);
  assign w_accept = rx_valid & rx_ready;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      idx_q      <= 2'd0;
      hold_q     <= '0;
      delay_q    <= '0;
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      ready_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      hold_q     <= hold_d;
      delay_q    <= delay_d;
      sync1_q    <= btn_n;
      sync2_q    <= sync1_q;
      ready_en_q <= 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Button hold counter: saturates at HOLD_CYCLES so a held button yields a
  // single trigger until it is released.
  // --------------------------------------------------------------------------
  always_comb begin
    hold_d     = hold_q;
    w_btn_trig = 1'b0;
    if (sync2_q) begin
      hold_d = '0;
    end else if (hold_q != c_HOLD_MAX) begin
      hold_d     = hold_q + c_HOLD_ONE;
      w_btn_trig = (hold_q == c_HOLD_LAST);
    end
  end

  // --------------------------------------------------------------------------
  // Next state, byte matcher and delay counter
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    delay_d     = delay_q;
    w_byte_trig = 1'b0;

    // Bytes are only accepted in IDLE, so the matcher only moves there.
    if (w_accept) begin
      if (rx_data == magic_byte(idx_q)) begin
        if (idx_q == 2'd3) begin
          w_byte_trig = 1'b1;
          idx_d       = 2'd0;
        end else begin
          idx_d = idx_q + 2'd1;
        end
      end else if (rx_data == magic_byte(2'd0)) begin
        // A mismatching byte may itself start a new sequence.
        idx_d = 2'd1;
      end else begin
        idx_d = 2'd0;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (w_byte_trig || w_btn_trig) begin
          state_d = S_COUNTDOWN;
          delay_d = c_DELAY_LOAD;
          idx_d   = 2'd0;
        end
      end
      S_COUNTDOWN: begin
        // cancel wins over firing on the same edge.
        if (cancel) begin
          state_d = S_IDLE;
          idx_d   = 2'd0;
        end else if (delay_q == c_DELAY_ZERO) begin
          state_d = S_FIRED;
        end else begin
          delay_d = delay_q - c_DELAY_ONE;
        end
      end
      S_FIRED: begin
        state_d = S_FIRED;
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = 2'd0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_reboot_trigger.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_reboot_trigger
// Purpose  : Directed and randomized stimulus for reboot_trigger, checked
//            against a behavioural reference model after every clock edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reboot_trigger;

  localparam int          HOLD  = 16;
  localparam int          DELAY = 8;
  localparam logic [31:0] MAGIC = 32'h52535421;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       rx_ready;
  logic       btn_n = 1'b1;
  logic       cancel = 1'b0;
  logic       pending;
  logic       do_reset;

  reboot_trigger #(
    .MAGIC        (MAGIC),
    .HOLD_CYCLES  (HOLD),
    .DELAY_CYCLES (DELAY)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .btn_n    (btn_n),
    .cancel   (cancel),
    .pending  (pending),
    .do_reset (do_reset)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state
  bit          m_ready_en;
  bit          m_pending;
  bit          m_fired;
  int          m_remaining;
  int          m_run;
  logic [7:0]  m_hist[$];   // last accepted bytes since entering IDLE
  bit          m_btnq[$];   // button levels driven at the previous two edges

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s at t=%0t observed=%b expected=%b", tag, $time, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ready_en  = 1'b0;
    m_pending   = 1'b0;
    m_fired     = 1'b0;
    m_remaining = 0;
    m_run       = 0;
    m_hist.delete();
    m_btnq = '{1'b1, 1'b1};
  endtask

  // One clock edge of the specified behaviour, evaluated on pre-edge state.
  task automatic model_edge(input logic v, input logic [7:0] d, input logic b, input logic c);
    bit          accept;
    bit          seen;
    bit          byte_trig;
    bit          btn_trig;
    logic [31:0] last4;
    accept    = v && m_ready_en && !m_pending;
    byte_trig = 1'b0;
    btn_trig  = 1'b0;

    // The button is seen two edges after it is driven.
    seen = m_btnq.pop_front();
    m_btnq.push_back(b);
    if (seen) m_run = 0;
    else if (m_run < HOLD) begin
      m_run++;
      if (m_run == HOLD) btn_trig = 1'b1;
    end

    if (accept) begin
      m_hist.push_back(d);
      if (m_hist.size() > 4) void'(m_hist.pop_front());
      if (m_hist.size() == 4) begin
        last4 = {m_hist[0], m_hist[1], m_hist[2], m_hist[3]};
        if (last4 == MAGIC) byte_trig = 1'b1;
      end
    end

    if (!m_pending) begin
      if (byte_trig || btn_trig) begin
        m_pending   = 1'b1;
        m_remaining = DELAY;
        m_hist.delete();
      end
    end else if (!m_fired) begin
      if (c) begin
        m_pending = 1'b0;
        m_hist.delete();
      end else begin
        m_remaining--;
        if (m_remaining == 0) m_fired = 1'b1;
      end
    end
    m_ready_en = 1'b1;
  endtask

  task automatic step(input logic v, input logic [7:0] d, input logic b, input logic c);
    rx_valid = v;
    rx_data  = d;
    btn_n    = b;
    cancel   = c;
    @(posedge clk);
    model_edge(v, d, b, c);
    #1;
    check("rx_ready", rx_ready, m_ready_en && !m_pending);
    check("pending",  pending,  m_pending);
    check("do_reset", do_reset, m_fired);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic send4(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) step(1'b1, w[8*i +: 8], 1'b1, 1'b0);
  endtask

  // Asynchronous reset pulse; outputs must drop before any clock edge.
  task automatic do_rst();
    rst = 1'b1;
    #1;
    check("rst_pending",  pending,  1'b0);
    check("rst_do_reset", do_reset, 1'b0);
    check("rst_rx_ready", rx_ready, 1'b0);
    model_reset();
    rx_valid = 1'b0;
    btn_n    = 1'b1;
    cancel   = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] mw;
    int          bi;
    bit          btn_lvl;
    logic        v;
    logic [7:0]  d;

    // Reset state
    #3;
    check("init_pending",  pending,  1'b0);
    check("init_do_reset", do_reset, 1'b0);
    check("init_rx_ready", rx_ready, 1'b0);
    model_reset();
    @(posedge clk);
    #2;
    rst = 1'b0;
    idle(1);
    check("ready_after_rst", rx_ready, 1'b1);

    // MAGIC with rx_valid held: pending on the 21 edge, fire 8 edges later
    send4(MAGIC);
    check("magic_pending", pending, 1'b1);
    for (int i = 1; i <= DELAY; i++) begin
      step(1'b1, 8'h52, 1'b1, 1'b0);
      check("cd_rx_ready", rx_ready, 1'b0);
      if (i == DELAY - 1) check("cd_not_yet", do_reset, 1'b0);
      if (i == DELAY)     check("cd_fired",   do_reset, 1'b1);
    end

    // Reset while fired clears outputs without a clock edge
    do_rst();
    idle(1);

    // Mismatch re-arms at index 1
    step(1'b1, 8'h52, 1'b1, 1'b0);
    send4(MAGIC);
    check("rearm_pending", pending, 1'b1);
    idle(DELAY);
    check("rearm_fired", do_reset, 1'b1);
    do_rst();
    idle(1);

    // Broken sequence never triggers
    mw = 32'h52530054;
    send4(mw);
    step(1'b1, 8'h21, 1'b1, 1'b0);
    idle(3);
    check("broken_no_trig", pending, 1'b0);

    // Button: 15 low samples do nothing, 16 trigger, holding after fire is inert
    for (int i = 0; i < HOLD - 1; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
    idle(20);
    check("btn15_no_trig", pending, 1'b0);
    for (int i = 1; i <= HOLD + 2; i++) begin
      step(1'b0, 8'h00, 1'b0, 1'b0);
      if (i == HOLD + 1) check("btn16_not_yet", pending, 1'b0);
    end
    check("btn16_pending", pending, 1'b1);
    for (int i = 0; i < DELAY + 20; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
    check("btn_hold_fired", do_reset, 1'b1);
    check("btn_hold_pend",  pending,  1'b1);
    do_rst();
    idle(2);

    // Cancel at countdown edge 5
    send4(MAGIC);
    idle(4);
    step(1'b0, 8'h00, 1'b1, 1'b1);
    check("cancel5_pending",  pending,  1'b0);
    check("cancel5_rx_ready", rx_ready, 1'b1);
    // Cancel on the would-fire edge
    send4(MAGIC);
    idle(DELAY - 1);
    step(1'b0, 8'h00, 1'b1, 1'b1);
    check("cancel8_do_reset", do_reset, 1'b0);
    check("cancel8_pending",  pending,  1'b0);
    // Fresh countdown afterwards
    send4(MAGIC);
    idle(DELAY - 1);
    check("fresh_not_yet", do_reset, 1'b0);
    idle(1);
    check("fresh_fired", do_reset, 1'b1);
    do_rst();
    idle(2);

    // Byte trigger and button trigger on the same edge
    mw = MAGIC;
    for (int i = 1; i <= HOLD + 2; i++) begin
      if (i >= HOLD - 1) step(1'b1, mw[8*(HOLD + 2 - i) +: 8], 1'b0, 1'b0);
      else               step(1'b0, 8'h00, 1'b0, 1'b0);
    end
    check("both_pending", pending, 1'b1);
    for (int i = 0; i < DELAY - 1; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
    check("both_not_yet", do_reset, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    check("both_fired", do_reset, 1'b1);
    do_rst();
    idle(2);

    // Randomized traffic
    bi      = 0;
    btn_lvl = 1'b1;
    mw      = MAGIC;
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_rst();
      end else begin
        v = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 7) == 0) d = 8'($urandom);
        else                           d = mw[8*(3 - (bi % 4)) +: 8];
        if (v) bi++;
        if ($urandom_range(0, 11) == 0) btn_lvl = ~btn_lvl;
        step(v, d, btn_lvl, ($urandom_range(0, 39) == 0));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
